muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit owning the HI/LO register pair, replacing the
//  single-cycle 64-bit multiply path beside the datapath ALU. Executes MULT/MULTU/DIV/DIVU
//  over several cycles with a start/busy/done handshake. Also executes MTHI/MTLO.
//  The controller stalls on busy before issuing MFHI/MFLO or the next op.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are WIDTH bits each
//  UNROLL   1  result bits retired per RUN cycle; must divide WIDTH (1,2,4,8)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  start        in   1      op request; sampled only when busy=0
//  op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  rs_data      in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//  rt_data      in   WIDTH  multiplier / divisor
//  busy         out  1      arithmetic op in flight
//  done         out  1      one-cycle pulse: HI/LO just updated by an arithmetic op
//  div_by_zero  out  1      valid with done; divisor was zero
//  hi, lo       out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
//  Reset (async assert, any state): state=IDLE, busy=0, done=0, div_by_zero=0,
//   hi=lo=0, internal counters/accumulators=0. Reset mid-operation aborts the op.
//  N = WIDTH/UNROLL. FSM: IDLE -> RUN (N cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE: start=1 and op in {000..011} at edge E0: latch operands as magnitudes
//   (signed ops take |x|, record result signs), counter=N, busy=1 from E0.
//   start=1 with op 100/101: hi (or lo) <= rs_data at E0; busy stays 0, no done.
//   op 110/111: no-op. start=0: hold.
//  RUN: per cycle retire UNROLL bits: multiply = shift-add into 2*WIDTH accumulator;
//   divide = restoring subtract-shift; decrement counter; counter 1 -> FIX.
//  FIX: apply sign correction; at edge E0+N+1 write hi/lo, busy<=0, done<=1 for one
//   cycle, div_by_zero<=flag for that cycle; return to IDLE.
//  Latency: start edge to hi/lo update = N+1 cycles (33 for WIDTH=32, UNROLL=1).
//  start while busy=1 is ignored (no queueing) for all ops incl. MTHI/MTLO;
//   operands are not re-sampled while busy. A start in the done cycle (busy=0) is
//   accepted normally, so back-to-back ops have N+1-cycle spacing.
//  hi/lo hold their previous values during RUN/FIX; updated only at FIX exit or MTHI/MTLO.
//  Multiply: {hi,lo} = full 2*WIDTH product; MULT signed, MULTU unsigned.
//  Divide: lo = quotient, hi = remainder. Signed: quotient truncates toward zero,
//   remainder takes dividend sign. DIV of MIN / -1: lo=MIN, hi=0, no flag.
//  Divisor 0 (DIV or DIVU): full latency still taken; hi=rs_data, lo=all ones,
//   div_by_zero=1 with done.
//  No output combinationally depends on inputs; all outputs are registered.
// TESTING
//  1 MULT 7 * -3 (0xFFFFFFFD): done after 33 cycles; hi=FFFFFFFF, lo=FFFFFFEB.
//  2 MULTU FFFFFFFF*FFFFFFFF: hi=FFFFFFFE, lo=00000001; repeat UNROLL=4: latency 9.
//  3 DIV -7/2: lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF: lo=80000000, hi=0.
//  4 DIVU 5/0: hi=00000005, lo=FFFFFFFF, div_by_zero=1 with done only.
//  5 MULT 3*4 running, start MTLO 0xAA at cycle 5: ignored; final lo=0000000C.
//    After done, MTHI 0x55: hi=00000055 next edge, busy never set, done=0.
//  6 reset low at cycle 10 of DIVU: busy=0, hi=lo=0 immediately; after release, DIVU
//    100/7 completes normally: lo=0000000E, hi=00000002.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO register pair.
// One shared 2*WIDTH accumulator serves shift-add multiply and restoring divide.
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   mag;
    logic               is_div, neg_q, neg_r, dz;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                    input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? ~x + WIDTH'(1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? ~x + WIDTH'(1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? ~x + (2*WIDTH)'(1) : x;
    endfunction

    // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] a,
                                                input logic [WIDTH-1:0]   m,
                                                input logic               div);
        logic [WIDTH:0] t;
        if (div) begin
            t = {a[2*WIDTH-1:WIDTH], a[WIDTH-1]};
            if (t >= {1'b0, m})
                return {WIDTH'(t - {1'b0, m}), a[WIDTH-2:0], 1'b1};
            return {t[WIDTH-1:0], a[WIDTH-2:0], 1'b0};
        end
        t = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : '0);
        return {t, a[WIDTH-1:1]};
    endfunction

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < UNROLL; i++) begin
            acc_next = step(acc_next, mag, is_div);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !op[2]) state_next = RUN;
            RUN:     if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            acc         <= '0;
            mag         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        // op[0]=0 marks the signed variants (MULT, DIV)
                        is_div <= op[1];
                        mag    <= magnitude(rt_data, !op[0]);
                        acc    <= {{WIDTH{1'b0}}, magnitude(rs_data, !op[0])};
                        neg_q  <= !op[0] && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_r  <= !op[0] && rs_data[WIDTH-1];
                        dz     <= op[1] && (rt_data == '0);
                        cnt    <= CW'(N);
                        busy   <= 1'b1;
                    end else if (start && op == OP_MTHI) begin
                        hi <= rs_data;
                    end else if (start && op == OP_MTLO) begin
                        lo <= rs_data;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
                        lo <= dz ? '1 : neg_w(acc[WIDTH-1:0], neg_q);
                    end else begin
                        {hi, lo} <= neg_2w(acc, neg_q);
                    end
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit: cycle-level reference model plus directed literal cases.
module tb_muldiv_unit;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start4 = 1'b0;
    logic [2:0]  op4 = 3'd0;
    logic [31:0] rs4 = 32'd0, rt4 = 32'd0;
    logic        busy4, done4, dz4;
    logic [31:0] hi4, lo4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
        .clk(clk), .reset(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk(clk), .reset(reset_n), .start(start4), .op(op4),
        .rs_data(rs4), .rt_data(rt4), .busy(busy4), .done(done4),
        .div_by_zero(dz4), .hi(hi4), .lo(lo4)
    );

    // Returns {div_by_zero, hi, lo} from plain arithmetic on the operands.
    function automatic logic [64:0] model_fn(input logic [2:0] o, input logic [31:0] a, b);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, sp};
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            3'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
            default: return 65'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level reference: latency countdown, pending result, MTHI/MTLO only when idle.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [64:0] pend = 65'd0;
    int          m_left = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0;
            m_done <= 1'b0; m_dz <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_dz, m_hi, m_lo} <= pend;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        pend   <= model_fn(op, rs_data, rt_data);
                        m_left <= LAT;
                        m_busy <= 1'b1;
                    end
                    3'd4: m_hi <= rs_data;
                    3'd5: m_lo <= rs_data;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_dz", div_by_zero, m_dz);
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(1, 9);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic wait_done(input bit noisy, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (noisy) begin
                start = ($urandom_range(0, 3) == 0);
                op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
            end
        end
        start = 1'b0;
        if (!done) chk("done_seen", 64'd0, 64'd1);
    endtask

    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input bit noisy);
        logic [64:0] e;
        int          cyc;
        e = model_fn(o, a, b);
        issue(o, a, b);
        wait_done(noisy, cyc);
        chk("latency", 64'(cyc), 64'(LAT));
        chk("res_hi", hi, e[63:32]);
        chk("res_lo", lo, e[31:0]);
        chk("res_dz", div_by_zero, e[64]);
    endtask

    task automatic run4(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [64:0] got, output int cyc);
        start4 = 1'b1; op4 = o; rs4 = a; rt4 = b;
        @(negedge clk);
        start4 = 1'b0; rs4 = $urandom; rt4 = $urandom;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done4) break;
        end
        got = {dz4, hi4, lo4};
    endtask

    initial begin
        int          cyc;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [64:0] got;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 64'd0);
        chk("rst_busy", busy, 64'd0);

        // Model pinned against hand-computed values
        chk("model_mult", model_fn(3'd0, 32'd7, 32'hFFFFFFFD), 64'hFFFFFFFF_FFFFFFEB);
        chk("model_div", model_fn(3'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);

        run_arith(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
        chk("t1_hi", hi, 64'hFFFFFFFF);
        chk("t1_lo", lo, 64'hFFFFFFEB);

        run_arith(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("t2_hi", hi, 64'hFFFFFFFE);
        chk("t2_lo", lo, 64'h00000001);

        run_arith(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("t3a_lo", lo, 64'hFFFFFFFD);
        chk("t3a_hi", hi, 64'hFFFFFFFF);
        run_arith(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("t3b_lo", lo, 64'h80000000);
        chk("t3b_hi", hi, 64'h0);
        chk("t3b_dz", div_by_zero, 64'd0);

        run_arith(3'd3, 32'd5, 32'd0, 1'b0);
        chk("t4_hi", hi, 64'h5);
        chk("t4_lo", lo, 64'hFFFFFFFF);
        chk("t4_dz", div_by_zero, 64'd1);
        @(negedge clk);
        chk("t4_dz_pulse", div_by_zero, 64'd0);

        // MTLO while busy must be dropped
        issue(3'd0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; rs_data = 32'hAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, cyc);
        chk("t5_latency", 64'(cyc + 4), 64'(LAT));
        chk("t5_lo", lo, 64'h0000000C);
        chk("t5_hi", hi, 64'h0);
        start = 1'b1; op = 3'd4; rs_data = 32'h55;
        @(negedge clk);
        start = 1'b0;
        chk("t5_mthi", hi, 64'h55);
        chk("t5_mthi_busy", busy, 64'd0);
        chk("t5_mthi_done", done, 64'd0);

        // Reset mid-divide aborts and clears HI/LO immediately
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 64'd0);
        chk("t6_hi", hi, 64'd0);
        chk("t6_lo", lo, 64'd0);
        chk("t6_done", done, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        run_arith(3'd3, 32'd100, 32'd7, 1'b0);
        chk("t6_lo2", lo, 64'h0000000E);
        chk("t6_hi2", hi, 64'h00000002);

        // Random traffic with stray starts while busy; issues land in the done cycle
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            if (!o[2]) run_arith(o, a, b, 1'b1);
            else issue(o, a, b);
        end

        // UNROLL=4 instance: latency N+1 = 9
        run4(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, got, cyc);
        chk("u4_latency", 64'(cyc), 64'd9);
        chk("u4_hi", got[63:32], 64'hFFFFFFFE);
        chk("u4_lo", got[31:0], 64'h00000001);
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 3));
            a = rnd_operand();
            b = rnd_operand();
            run4(o, a, b, got, cyc);
            chk("u4_rnd_latency", 64'(cyc), 64'd9);
            chk("u4_rnd_res", got[63:0], model_fn(o, a, b) & 65'h0_FFFFFFFF_FFFFFFFF);
            chk("u4_rnd_dz", got[64], model_fn(o, a, b) >> 64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
